// File: rtl/ram_master.sv
// Initiator-side sequencer for the single-port synchronous ram: request channel in, RAM strobes out.
// Optional write-verify read-back is enabled by defining RAM_MASTER_WR_VERIFY_EN.
module ram_master #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_BITS-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy,
  output logic                    verify_err,
  output logic                    read_memory,
  output logic                    write_memory,
  output logic [ADDRESS_BITS-1:0] address,
  output logic [DATA_WIDTH-1:0]   write_memory_data,
  input  logic [DATA_WIDTH-1:0]   read_memory_data
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, WAIT, RESP
`ifdef RAM_MASTER_WR_VERIFY_EN
    , VRD, VWAIT
`endif
  } state_t;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]   wdata;
  } req_t;

  localparam bit         ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [2:0] LAT_LAST = 3'(ZERO_LAT ? 0 : READ_LATENCY - 1);

  state_t     state_q, state_d;
  req_t       req_q;
  logic [2:0] cnt_q;
  logic       accept, lat_done, in_wait, cap_rd;

  assign accept   = req_valid && req_ready;
  assign lat_done = (cnt_q == LAT_LAST);
  // With zero latency the RAM answers combinationally, so capture at the end of the strobe cycle.
  assign cap_rd   = (state_q == RD && ZERO_LAT) || (state_q == WAIT && lat_done);

`ifdef RAM_MASTER_WR_VERIFY_EN
  logic verr_q, cmp;
  assign in_wait    = (state_q == WAIT) || (state_q == VWAIT);
  assign cmp        = (state_q == VRD && ZERO_LAT) || (state_q == VWAIT && lat_done);
  assign verify_err = verr_q;
`else
  assign in_wait    = (state_q == WAIT);
  assign verify_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = req_write ? WR : RD;
`ifdef RAM_MASTER_WR_VERIFY_EN
      WR:    state_d = VRD;
      VRD:   state_d = ZERO_LAT ? IDLE : VWAIT;
      VWAIT: if (lat_done) state_d = IDLE;
`else
      WR:    state_d = IDLE;
`endif
      RD:    state_d = ZERO_LAT ? RESP : WAIT;
      WAIT:  if (lat_done) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE) && rst_n;
    busy         = (state_q != IDLE);
    write_memory = (state_q == WR);
    rsp_valid    = (state_q == RESP);
`ifdef RAM_MASTER_WR_VERIFY_EN
    read_memory  = (state_q == RD) || (state_q == VRD);
`else
    read_memory  = (state_q == RD);
`endif
  end

  assign address           = req_q.addr;
  assign write_memory_data = req_q.wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rsp_rdata <= '0;
`ifdef RAM_MASTER_WR_VERIFY_EN
      verr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= in_wait ? cnt_q + 3'd1 : 3'd0;
      if (accept) req_q <= '{addr: req_addr, wdata: req_wdata};
      if (cap_rd) rsp_rdata <= read_memory_data;
`ifdef RAM_MASTER_WR_VERIFY_EN
      if (cmp && read_memory_data != req_q.wdata) verr_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Randomized scoreboard bench for ram_master with a behavioural RAM that corrupts bit 0 of reads at 0x5.
module tb_ram_master;
  localparam int AB = 4;
  localparam int DW = 16;
  parameter int READ_LATENCY = 1;
`ifdef RAM_MASTER_WR_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif
  localparam int LI  = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;
  localparam int BIG = 32'h7fffffff;

  logic clk, rst_n, req_valid, req_ready, req_write, rsp_valid, busy, verify_err;
  logic read_memory, write_memory;
  logic [AB-1:0] req_addr, address;
  logic [DW-1:0] req_wdata, rsp_rdata, write_memory_data, read_memory_data;

  ram_master #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .READ_LATENCY(READ_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .verify_err(verify_err),
    .read_memory(read_memory), .write_memory(write_memory), .address(address),
    .write_memory_data(write_memory_data), .read_memory_data(read_memory_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with READ_LATENCY edges from the end of the read strobe to valid data
  logic [DW-1:0] mem  [0:15];
  logic [DW-1:0] pipe [0:7];
  logic [DW-1:0] raw;
  assign raw = mem[address] ^ {{(DW-1){1'b0}}, address == 4'd5};
  assign read_memory_data = (READ_LATENCY == 0) ? (read_memory ? raw : 16'hDEAD) : pipe[LI];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (write_memory) mem[address] <= write_memory_data;
    pipe[0] <= read_memory ? raw : 16'hDEAD;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model state
  typedef struct {int cyc; bit wr;} strb_t;
  typedef struct {int cyc; logic [DW-1:0] d;} rsp_t;
  strb_t sq[$];
  rsp_t  rq[$];
  logic [DW-1:0] ref_mem [0:15];
  logic [AB-1:0] last_addr;
  logic [DW-1:0] last_wdata, last_rdata;
  int cyc = 0, ready_at = 0, err_at = BIG, acc_cnt = 0;
  bit started = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Accept tracking: a request is taken whenever the spec says the block is ready
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sq.delete(); rq.delete();
        ready_at = 0; err_at = BIG; started = 1;
        last_addr = '0; last_wdata = '0; last_rdata = '0;
      end else if (started && req_valid && cyc >= ready_at) begin
        acc_cnt++;
        last_addr  = req_addr;
        last_wdata = req_wdata;
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
          sq.push_back('{cyc + 1, 1'b1});
          if (VEN) begin
            sq.push_back('{cyc + 2, 1'b0});
            ready_at = cyc + 3 + READ_LATENCY;
            if (req_addr == 4'd5 && err_at == BIG) err_at = ready_at;
          end else ready_at = cyc + 2;
        end else begin
          sq.push_back('{cyc + 1, 1'b0});
          rq.push_back('{cyc + 2 + READ_LATENCY,
                         ref_mem[req_addr] ^ {{(DW-1){1'b0}}, req_addr == 4'd5}});
          ready_at = cyc + 3 + READ_LATENCY;
        end
      end
      cyc++;
    end
  end

  // Monitor: compares DUT outputs against the model every cycle
  initial begin
    bit ew, er;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (started) begin
        ew = 0; er = 0;
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL strobe_missed cyc=%0d got=none exp_cyc=%0d", cyc, sq[0].cyc);
          void'(sq.pop_front());
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
          ew = sq[0].wr; er = !sq[0].wr;
          void'(sq.pop_front());
        end
        chk("write_memory", write_memory, ew);
        chk("read_memory", read_memory, er);
        chk("address", address, last_addr);
        chk("write_memory_data", write_memory_data, last_wdata);
        chk("req_ready", req_ready, rst_n && cyc >= ready_at);
        chk("busy", busy, cyc < ready_at);
        chk("verify_err", verify_err, cyc >= err_at);
        if (rsp_valid) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_spurious cyc=%0d got=%h exp=none", cyc, rsp_rdata);
          end else begin
            r = rq.pop_front();
            chk("rsp_cycle", cyc, r.cyc);
            chk("rsp_rdata", rsp_rdata, r.d);
            last_rdata = r.d;
          end
        end else begin
          if (rq.size() > 0 && rq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL rsp_missed cyc=%0d got=none exp_cyc=%0d", cyc, rq[0].cyc);
            void'(rq.pop_front());
          end
          chk("rsp_hold", rsp_rdata, last_rdata);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input bit w, input logic [AB-1:0] a, input logic [DW-1:0] d, input bit hold);
    int start, n;
    start = acc_cnt; n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (acc_cnt == start && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt == start) begin
      checks++; errors++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [AB-1:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    // corner addresses and data
    send(1'b1, 4'hF, 16'hFFFF, 1'b0);
    send(1'b1, 4'hE, 16'hFF00, 1'b0);
    send(1'b0, 4'hF, 16'h1111, 1'b0);
    idle(2);
    send(1'b0, 4'hE, 16'h2222, 1'b0);
    idle(4);
    send(1'b1, 4'h6, 16'h5A5A, 1'b0);
    // held valid, alternating write/read on address 0
    for (int i = 0; i < 8; i++) send(i % 2 == 0, 4'h0, 16'($urandom), 1'b1);
    req_valid = 1'b0;
    idle(5);
    // random traffic, address 5 kept clean until the verify test
    for (int i = 0; i < 80; i++) begin
      a = 4'($urandom_range(0, 15));
      if (a == 4'd5) a = 4'd4;
      send(1'($urandom), a, 16'($urandom), 1'($urandom));
      if (!req_valid) idle($urandom_range(0, 2));
    end
    req_valid = 1'b0;
    idle(6);
    // reset in the middle of a read
    send(1'b0, 4'hF, 16'h0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    send(1'b0, 4'hE, 16'h0, 1'b0);
    send(1'b0, 4'h6, 16'h0, 1'b0);
    // write verify: clean write, corrupted write, then more clean traffic
    send(1'b1, 4'h6, 16'h0001, 1'b0);
    idle(3);
    send(1'b1, 4'h5, 16'h1234, 1'b0);
    idle(3);
    send(1'b1, 4'h6, 16'hBEEF, 1'b0);
    send(1'b0, 4'h5, 16'h0, 1'b0);
    send(1'b0, 4'h6, 16'h0, 1'b0);
    idle(12);
    chk("strobe_queue_drained", sq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end
endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator-side sequencer for the single-port synchronous `ram` block.
- Accepts host transactions on a valid/ready request channel and drives the RAM strobes (`read_memory`, `write_memory`), `address` and `write_memory_data`.
- Captures `read_memory_data` after the configured read latency and returns it on a one-cycle response strobe.
- Replaces hand-timed testbench stimulus and is the standard path by which any client reaches the RAM.

Parameters:
ADDRESS_BITS, 4, width of request and RAM address
DATA_WIDTH, 16, width of write and read data
READ_LATENCY, 1, clock edges from the end of the `read_memory` cycle to valid `read_memory_data`; legal range 0..7

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
req_valid  input  1  host request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = write, 0 = read; sampled on accept
req_addr  input  ADDRESS_BITS  request address; sampled on accept
req_wdata  input  DATA_WIDTH  write data; sampled on accept
rsp_valid  output  1  one-cycle pulse: rsp_rdata holds read result
rsp_rdata  output  DATA_WIDTH  read result; held until the next read response
busy  output  1  high whenever the FSM is not in IDLE
verify_err  output  1  sticky write-verify mismatch flag (see Optional Feature)
read_memory  output  1  RAM read strobe
write_memory  output  1  RAM write strobe
address  output  ADDRESS_BITS  RAM address
write_memory_data  output  DATA_WIDTH  RAM write data
read_memory_data  input  DATA_WIDTH  RAM read data

Behaviour:
- One clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: at any rising edge with rst_n=0:
  - FSM goes to IDLE.
  - read_memory, write_memory, rsp_valid, busy, verify_err = 0.
  - address = 0, write_memory_data = 0, rsp_rdata = 0.
  - Any transaction in flight is aborted; strobes are low from that edge onward.
  - The aborted transaction produces no response.
- req_ready = 1 only in IDLE with rst_n=1 (registered state, no combinational path from req_valid). A request is accepted on an edge where req_valid && req_ready.
- On accept, req_addr and req_wdata are registered onto address and write_memory_data. Both hold stable until the next accept.
- FSM states:
  - IDLE: wait for accept. req_write=1 -> WR; req_write=0 -> RD.
  - WR: write_memory=1 for exactly one cycle. Next state IDLE, or VRD when verify is enabled.
  - RD: read_memory=1 for exactly one cycle. Next state WAIT if READ_LATENCY>0. If READ_LATENCY=0, read_memory_data is captured at the end of RD and the next state is RESP.
  - WAIT: a 3-bit counter runs for READ_LATENCY cycles. read_memory_data is captured into rsp_rdata on the final WAIT edge. Next state RESP.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
  - VRD/VWAIT: verify read, described under Optional Feature.
- Latency with defaults, accept on edge E:
  - Write: write_memory high in cycle E+1; req_ready high again in cycle E+2.
  - Read: read_memory high in E+1, WAIT in E+2, rsp_valid high in E+3, req_ready high in E+4.
- read_memory and write_memory are never high in the same cycle.
- Back-to-back operation:
  - A request held valid across the ready-low cycles is accepted on the first ready-high edge.
  - req_valid is ignored while req_ready=0.
- busy = (state != IDLE).
- Address wrap is natural. Address 2^ADDRESS_BITS-1 is legal; no bounds check is performed.
- A write never produces rsp_valid.

Optional Feature:
- Macro: RAM_MASTER_WR_VERIFY_EN.
- With the macro defined:
  - After WR, the FSM enters VRD and pulses read_memory for one cycle at the same address.
  - It then waits READ_LATENCY cycles (VWAIT), compares read_memory_data against write_memory_data, and returns to IDLE.
  - On mismatch, verify_err is set. It is sticky and cleared only by reset.
  - The verify read does not pulse rsp_valid and does not update rsp_rdata.
  - Write occupancy grows to 3+READ_LATENCY cycles.
- Without the macro: verify_err is tied to 0, VRD/VWAIT are not present, and a write takes 2 cycles.

Test Plan:
- Reset: rst_n=0 for 2 edges mid-read (during WAIT) -> strobes 0 at the first low edge, no rsp_valid, req_ready=1 after release.
- Write address 0xF data 0xFFFF, then address 0xE data 0xFF00 -> write_memory one cycle each; address/write_memory_data match the requests; no rsp_valid.
- Read 0xF, then read 0xE -> rsp_valid pulses 3 cycles after each accept, with rsp_rdata=0xFFFF then 0xFF00; rsp_rdata holds between pulses.
- req_valid held high with alternating write/read to 0x0 -> no request dropped or duplicated; read_memory/write_memory never overlap.
- READ_LATENCY=0 and READ_LATENCY=3 builds -> rsp_valid appears at accept+2 and accept+5 respectively, with correct data.
- RAM_MASTER_WR_VERIFY_EN defined, RAM model forced to corrupt bit 0 on address 0x5, write 0x1234 -> verify_err=1 and sticky. A clean write to 0x6 -> verify_err stays 0 until that point, with no rsp_valid.
